// File: rtl/alloc_requester.sv
// alloc_requester: per-slot job front end for the separable allocator; `define REQ_TIMEOUT_EN adds a REQ-state timeout
module alloc_requester #(
  parameter int NUM_REQS = 4,
  parameter int NUM_RESS = 3,
  parameter int LEN_W = 4,
  parameter int TIMEOUT = 15,
  localparam int RW = NUM_RESS > 1 ? $clog2(NUM_RESS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] in_valid,
  output logic [NUM_REQS-1:0] in_ready,
  input  logic [NUM_RESS-1:0] in_mask [NUM_REQS],
  input  logic [LEN_W-1:0]    in_len [NUM_REQS],
  output logic [NUM_RESS-1:0] requests [NUM_REQS],
  input  logic [NUM_REQS-1:0] grants [NUM_RESS],
  output logic [NUM_REQS-1:0] xfer_valid,
  output logic [RW-1:0]       xfer_res [NUM_REQS],
  output logic [NUM_REQS-1:0] done,
  output logic [NUM_RESS-1:0] res_busy,
  output logic                grant_err
`ifdef REQ_TIMEOUT_EN
  ,
  output logic [NUM_REQS-1:0] timeout
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} st_t;
  st_t st [NUM_REQS];
  st_t st_n [NUM_REQS];
  logic [NUM_RESS-1:0] m [NUM_REQS];
  logic [LEN_W-1:0] l [NUM_REQS];
  logic [LEN_W-1:0] c [NUM_REQS];
  logic [RW-1:0] h [NUM_REQS];
  logic [RW-1:0] tr [NUM_REQS];
  logic [NUM_REQS-1:0] tk;
  logic [NUM_REQS-1:0] to;
  logic gerr;
  logic fnd;
  logic ok;
  if (TIMEOUT < 1) $error("TIMEOUT must be at least 1");
`ifdef REQ_TIMEOUT_EN
  localparam int AW = $clog2(TIMEOUT + 1);
  logic [AW-1:0] age [NUM_REQS];
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++)
      to[i] = st[i] == REQ && age[i] == AW'(TIMEOUT - 1) && !tk[i];
  end
  assign timeout = to;
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++)
      age[i] <= reset ? '0 : st[i] == REQ ? age[i] + 1'b1 : '0;
  end
`else
  assign to = '0;
`endif
  // A resource goes to the lowest-index requesting slot; a slot keeps its lowest won resource.
  always_comb begin
    gerr = 1'b0;
    fnd = 1'b0;
    ok = 1'b0;
    tk = '0;
    for (int i = 0; i < NUM_REQS; i++) tr[i] = '0;
    for (int r = 0; r < NUM_RESS; r++) begin
      fnd = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
        if (grants[r][i]) begin
          ok = st[i] == REQ && !res_busy[r];
          gerr = gerr | !ok | fnd | tk[i];
          if (ok && !fnd && !tk[i]) begin
            tk[i] = 1'b1;
            tr[i] = RW'(r);
          end
          fnd = fnd | ok;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_err <= 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
        st[i] <= IDLE;
        m[i] <= '0;
        l[i] <= '0;
        c[i] <= '0;
        h[i] <= '0;
      end
    end else begin
      grant_err <= grant_err | gerr;
      for (int i = 0; i < NUM_REQS; i++) begin
        st[i] <= st_n[i];
        if (st[i] == IDLE && in_valid[i]) begin
          m[i] <= in_mask[i];
          l[i] <= in_len[i];
        end
        if (st[i] == REQ && tk[i]) begin
          h[i] <= tr[i];
          c[i] <= l[i];
        end
        if (st[i] == HOLD && c[i] != '0) c[i] <= c[i] - 1'b1;
      end
    end
  end
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++)
      st_n[i] = st[i] == IDLE ? (in_valid[i] ? REQ : IDLE)
              : st[i] == REQ ? (tk[i] ? HOLD : to[i] ? IDLE : REQ)
              : c[i] == '0 ? IDLE : HOLD;
  end
  always_comb begin
    res_busy = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      in_ready[i] = st[i] == IDLE;
      xfer_valid[i] = st[i] == HOLD;
      done[i] = st[i] == HOLD && c[i] == '0;
      xfer_res[i] = h[i];
      if (st[i] == HOLD) res_busy[h[i]] = 1'b1;
    end
    for (int i = 0; i < NUM_REQS; i++)
      requests[i] = st[i] == REQ ? m[i] & ~res_busy : '0;
  end
endmodule
